// File: rtl/seq_add_n.sv
// Multi-cycle W-bit adder/subtractor: CHUNK bits per clock, carry rippled through a register.
// Operands accepted with start/busy/done; the (W+1)-bit result is held until the next op completes.
//
// state | meaning
// IDLE  | waiting for start; r holds the last result
// RUN   | one chunk added per edge, chunk counter counting down
// DONE  | one-cycle done pulse; start here is accepted back-to-back
module seq_add_n #(
  parameter int W     = 8,
  parameter int CHUNK = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W:0]   r
);

  localparam int N  = W / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if ((W < 1) || (CHUNK < 1) || (CHUNK > W) || ((W % CHUNK) != 0)) begin : g_bad_param
    $error("seq_add_n: W must be >= 1 and a multiple of CHUNK, with 1 <= CHUNK <= W");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            accept;
  logic            last;

  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic            sub_q;
  logic            carry;
  logic [CW-1:0]   cnt;

  logic [CHUNK:0]  chunk_add;
  logic [W-1:0]    a_next;
  logic            flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == '0) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign chunk_add = {1'b0, op_a[CHUNK-1:0]} + {1'b0, op_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
  // Final carry means "no borrow" when subtracting, so invert it for the flag.
  assign flag      = chunk_add[CHUNK] ^ sub_q;

  // The A register doubles as the sum register: each chunk sum enters at the
  // top as the consumed A chunk leaves at the bottom, so after N steps it holds the full sum.
  if (CHUNK == W) begin : g_single
    assign a_next = chunk_add[CHUNK-1:0];
  end else begin : g_multi
    assign a_next = {chunk_add[CHUNK-1:0], op_a[W-1:CHUNK]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      sub_q <= 1'b0;
      carry <= 1'b0;
      cnt   <= '0;
      r     <= '0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= b ^ {W{sub}};
      sub_q <= sub;
      carry <= sub;
      cnt   <= CW'(N - 1);
    end else if (state == RUN) begin
      op_a  <= a_next;
      op_b  <= op_b >> CHUNK;
      carry <= chunk_add[CHUNK];
      cnt   <= cnt - CW'(1);
      if (last) begin
        r <= {flag, a_next};
      end
    end
  end

endmodule

// File: tb/tb_seq_add_n.sv
// Bench for seq_add_n: one W=8/CHUNK=2 instance for directed, random, back-to-back and reset
// tests, plus W=3 instances with CHUNK=1 and CHUNK=3 swept exhaustively against an arithmetic model.
module tb_seq_add_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start0, sub0, busy0, done0;
  logic [7:0] a0, b0;
  logic [8:0] r0;
  logic       start1, sub1, busy1, done1;
  logic [2:0] a1, b1;
  logic [3:0] r1;
  logic       start2, sub2, busy2, done2;
  logic [2:0] a2, b2;
  logic [3:0] r2;

  seq_add_n #(.W(8), .CHUNK(2)) u_w8c2 (
    .clk(clk), .rst(rst), .start(start0), .sub(sub0), .a(a0), .b(b0),
    .busy(busy0), .done(done0), .r(r0)
  );
  seq_add_n #(.W(3), .CHUNK(1)) u_w3c1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .r(r1)
  );
  seq_add_n #(.W(3), .CHUNK(3)) u_w3c3 (
    .clk(clk), .rst(rst), .start(start2), .sub(sub2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .r(r2)
  );

  int         total = 0;
  int         bad   = 0;
  logic [8:0] prev_r [3];

  function automatic int ref_r(input int w, input int x, input int y, input bit s);
    int m;
    m = (1 << w) - 1;
    if (s) return ((x - y) & m) | ((x < y) ? (1 << w) : 0);
    return x + y;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input bit st, input int x, input int y, input bit s);
    case (d)
      0: begin start0 = st; a0 = x[7:0]; b0 = y[7:0]; sub0 = s; end
      1: begin start1 = st; a1 = x[2:0]; b1 = y[2:0]; sub1 = s; end
      default: begin start2 = st; a2 = x[2:0]; b2 = y[2:0]; sub2 = s; end
    endcase
  endtask

  task automatic get_out(input int d, output logic bz, output logic dn, output logic [8:0] rr);
    case (d)
      0: begin bz = busy0; dn = done0; rr = r0; end
      1: begin bz = busy1; dn = done1; rr = {5'd0, r1}; end
      default: begin bz = busy2; dn = done2; rr = {5'd0, r2}; end
    endcase
  endtask

  task automatic run_op(input int d, input int w, input int n, input int x, input int y,
                        input bit s, input string tag);
    int         exp;
    int         lat;
    bit         seen;
    logic       bz, dn;
    logic [8:0] rr;
    exp = ref_r(w, x, y, s);
    drive(d, 1'b1, x, y, s);
    step();
    get_out(d, bz, dn, rr);
    chk({tag, " busy after accept"}, 32'(bz), 32'd1);
    chk({tag, " done after accept"}, 32'(dn), 32'd0);
    chk({tag, " r held at accept"}, 32'(rr), 32'(prev_r[d]));
    drive(d, 1'b0, int'($urandom), int'($urandom), bit'($urandom_range(1, 0)));
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < n + 4 && !seen; i++) begin
      step();
      lat++;
      get_out(d, bz, dn, rr);
      if (dn) begin
        seen = 1'b1;
      end else begin
        chk({tag, " busy during run"}, 32'(bz), 32'd1);
        chk({tag, " r held during run"}, 32'(rr), 32'(prev_r[d]));
      end
    end
    chk({tag, " done seen"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, 32'(lat), 32'(n));
    chk({tag, " result"}, 32'(rr), 32'(exp));
    chk({tag, " busy with done"}, 32'(bz), 32'd0);
    prev_r[d] = 9'(exp);
    step();
    get_out(d, bz, dn, rr);
    chk({tag, " done one cycle"}, 32'(dn), 32'd0);
    chk({tag, " result held"}, 32'(rr), 32'(exp));
  endtask

  int         va [16];
  int         vb [16];
  bit         vs [16];
  logic       bz, dn;
  logic [8:0] rr;
  int         exp_bb;
  bit         dexp;

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      drive(d, 1'b0, 0, 0, 1'b0);
      prev_r[d] = '0;
    end
    step();
    step();
    for (int d = 0; d < 3; d++) begin
      get_out(d, bz, dn, rr);
      chk($sformatf("reset busy d%0d", d), 32'(bz), 32'd0);
      chk($sformatf("reset done d%0d", d), 32'(dn), 32'd0);
      chk($sformatf("reset r d%0d", d), 32'(rr), 32'd0);
    end

    // reset and start at the same edge: reset must win
    drive(0, 1'b1, 5, 6, 1'b0);
    step();
    chk("rst+start busy", 32'(busy0), 32'd0);
    rst = 1'b0;
    drive(0, 1'b0, 0, 0, 1'b0);
    step();
    chk("rst+start stays idle", 32'(busy0), 32'd0);
    chk("rst+start no done", 32'(done0), 32'd0);

    run_op(0, 8, 4, 1, 3, 1'b0, "add 1+3");
    run_op(0, 8, 4, 8'hFF, 8'hFF, 1'b0, "add ff+ff");
    run_op(0, 8, 4, 3, 2, 1'b0, "add 3+2");
    run_op(0, 8, 4, 5, 3, 1'b1, "sub 5-3");
    run_op(0, 8, 4, 3, 5, 1'b1, "sub 3-5");
    run_op(0, 8, 4, 7, 7, 1'b1, "sub 7-7");
    run_op(0, 8, 4, 0, 8'hFF, 1'b1, "sub 0-ff");
    for (int i = 0; i < 24; i++) begin
      run_op(0, 8, 4, int'($urandom_range(255, 0)), int'($urandom_range(255, 0)),
             bit'($urandom_range(1, 0)), $sformatf("rand%0d", i));
    end

    // start held high with operands changing every cycle
    for (int e = 0; e < 16; e++) begin
      va[e] = int'($urandom_range(255, 0));
      vb[e] = int'($urandom_range(255, 0));
      vs[e] = bit'($urandom_range(1, 0));
    end
    drive(0, 1'b1, va[0], vb[0], vs[0]);
    for (int e = 0; e < 15; e++) begin
      step();
      dexp = ((e % 5) == 4);
      chk($sformatf("b2b done e%0d", e), 32'(done0), 32'(dexp));
      chk($sformatf("b2b busy e%0d", e), 32'(busy0), 32'(!dexp));
      if (dexp) begin
        exp_bb = ref_r(8, va[e - 4], vb[e - 4], vs[e - 4]);
        chk($sformatf("b2b result e%0d", e), 32'(r0), 32'(exp_bb));
        prev_r[0] = 9'(exp_bb);
      end else begin
        chk($sformatf("b2b r held e%0d", e), 32'(r0), 32'(prev_r[0]));
      end
      drive(0, e < 14, va[e + 1], vb[e + 1], vs[e + 1]);
    end
    step();
    chk("b2b stop busy", 32'(busy0), 32'd0);
    chk("b2b stop done", 32'(done0), 32'd0);
    chk("b2b stop r held", 32'(r0), 32'(prev_r[0]));

    // reset asserted during the second RUN cycle
    drive(0, 1'b1, 8'h55, 8'h66, 1'b0);
    step();
    drive(0, 1'b0, 0, 0, 1'b0);
    step();
    chk("abort busy before rst", 32'(busy0), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort busy", 32'(busy0), 32'd0);
    chk("abort done", 32'(done0), 32'd0);
    chk("abort r", 32'(r0), 32'd0);
    for (int d = 0; d < 3; d++) prev_r[d] = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("abort no done c%0d", i), 32'(done0), 32'd0);
    end
    run_op(0, 8, 4, 8'hA5, 8'h3C, 1'b0, "after abort add");
    run_op(0, 8, 4, 8'h3C, 8'hA5, 1'b1, "after abort sub");

    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 8; x++) begin
        for (int y = 0; y < 8; y++) begin
          run_op(1, 3, 3, x, y, bit'(s), $sformatf("w3c1 %0d %0d s%0d", x, y, s));
          run_op(2, 3, 1, x, y, bit'(s), $sformatf("w3c3 %0d %0d s%0d", x, y, s));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
